// File: rtl/param_shift_register.sv
// WIDTH-bit shift register with single-step modes and a one-bit-per-cycle burst engine.
// Optional macro PSR_ROTATE_EN builds rotate modes 100/101; without it they hold.
module param_shift_register #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
   parameter int               AMT_W       = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  logic             start,
   input  logic [AMT_W-1:0] amt,
   input  logic             dir,
   output logic [WIDTH-1:0] q,
   output logic             sout_msb,
   output logic             sout_lsb,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam logic [AMT_W-1:0] LP_WIDTH_AMT = AMT_W'(WIDTH);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_nxt;
   logic [AMT_W-1:0] r_cnt;
   logic [AMT_W-1:0] w_cnt_nxt;
   logic             r_dir;
   logic             w_dir_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic [AMT_W-1:0] w_amt_clamp;

   assign w_amt_clamp = (amt > LP_WIDTH_AMT) ? LP_WIDTH_AMT : amt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_q     <= RESET_VALUE;
         r_cnt   <= '0;
         r_dir   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dir   <= w_dir_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_cnt_nxt   = r_cnt;
      w_dir_nxt   = r_dir;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // start takes precedence over any single-step operation
            if (start) begin
               w_dir_nxt = dir;
               w_cnt_nxt = w_amt_clamp;
               if (w_amt_clamp == '0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_SHIFT;
                  w_busy_nxt  = 1'b1;
               end
            end else if (en) begin
               case (mode)
                  3'b001:  w_q_nxt = d;
                  3'b010:  w_q_nxt = {r_q[WIDTH-2:0], sin};
                  3'b011:  w_q_nxt = {sin, r_q[WIDTH-1:1]};
`ifdef PSR_ROTATE_EN
                  3'b100:  w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                  3'b101:  w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
`endif
                  3'b110:  w_q_nxt = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                  default: w_q_nxt = r_q;
               endcase
            end
         end
         ST_SHIFT: begin
            w_q_nxt   = r_dir ? {sin, r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], sin};
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt == AMT_W'(1)) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_busy_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign q        = r_q;
   assign sout_msb = r_q[WIDTH-1];
   assign sout_lsb = r_q[0];
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_param_shift_register.sv
// Randomised and directed bench for param_shift_register (WIDTH=8, RESET_VALUE=8'hA5)
// against a cycle-level behavioural model of q, busy and done.
module tb_param_shift_register;

   localparam int              W    = 8;
   localparam int              AW   = $clog2(W+1);
   localparam logic [W-1:0]    RV   = 8'hA5;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic [2:0]    mode;
   logic [W-1:0]  d;
   logic          sin;
   logic          start;
   logic [AW-1:0] amt;
   logic          dir;
   logic [W-1:0]  q;
   logic          sout_msb;
   logic          sout_lsb;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_errors = 0;

   // model state: register value, bursts bits still to shift, latched direction
   logic [W-1:0] m_q;
   int           m_left;
   logic         m_dir;
   logic         m_busy;
   logic         m_done;

   int busy_cnt;
   int done_cnt;

   always #5 clk = ~clk;

   param_shift_register #(
      .WIDTH       (W),
      .RESET_VALUE (RV)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .mode     (mode),
      .d        (d),
      .sin      (sin),
      .start    (start),
      .amt      (amt),
      .dir      (dir),
      .q        (q),
      .sout_msb (sout_msb),
      .sout_lsb (sout_lsb),
      .busy     (busy),
      .done     (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      int n;
      if (reset) begin
         m_q = RV; m_left = 0; m_busy = 1'b0; m_done = 1'b0;
      end else if (m_left > 0) begin
         if (m_dir) m_q = (m_q >> 1) | (W'(sin) << (W-1));
         else       m_q = W'((m_q << 1) | W'(sin));
         m_left = m_left - 1;
         m_busy = (m_left != 0);
         m_done = (m_left == 0);
      end else begin
         m_done = 1'b0;
         m_busy = 1'b0;
         if (start) begin
            n = (int'(amt) > W) ? W : int'(amt);
            m_dir = dir;
            if (n == 0) m_done = 1'b1;
            else begin m_left = n; m_busy = 1'b1; end
         end else if (en) begin
            case (mode)
               3'd1: m_q = d;
               3'd2: m_q = W'((m_q << 1) | W'(sin));
               3'd3: m_q = (m_q >> 1) | (W'(sin) << (W-1));
`ifdef PSR_ROTATE_EN
               3'd4: m_q = W'((m_q << 1) | (m_q >> (W-1)));
               3'd5: m_q = (m_q >> 1) | W'(m_q << (W-1));
`endif
               3'd6: m_q = (m_q >> 1) | (m_q & (W'(1) << (W-1)));
               default: ;
            endcase
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("q", 32'(q), 32'(m_q));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("sout_msb", 32'(sout_msb), 32'(m_q[W-1]));
      chk("sout_lsb", 32'(sout_lsb), 32'(m_q[0]));
      chk("done_busy_excl", 32'(done & busy), 32'd0);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
   endtask

   task automatic idle_inputs();
      en = 1'b0; mode = 3'd0; d = '0; sin = 1'b0; start = 1'b0; amt = '0; dir = 1'b0;
   endtask

   logic [W-1:0] rot_exp;

   initial begin
      m_q = '0; m_left = 0; m_dir = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      busy_cnt = 0; done_cnt = 0;
      idle_inputs();
      reset = 1'b1;
      step();
      chk("rst_q", 32'(q), 32'(RV));
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      step();
      reset = 1'b0;

      // single-step modes
      en = 1'b1; mode = 3'd1; d = 8'h81; step(); chk("load", 32'(q), 32'h81);
      mode = 3'd2; sin = 1'b0; step(); chk("shl", 32'(q), 32'h02);
      mode = 3'd3; sin = 1'b1; step(); chk("shr", 32'(q), 32'h81);
      mode = 3'd6; sin = 1'b0; step(); chk("ashr", 32'(q), 32'hC0);

      // rotate, or hold when rotate logic is not built
      mode = 3'd1; d = 8'h81; step();
`ifdef PSR_ROTATE_EN
      rot_exp = 8'h03;
`else
      rot_exp = 8'h81;
`endif
      mode = 3'd4; step(); chk("rotl", 32'(q), 32'(rot_exp));
      mode = 3'd5; step(); chk("rotr", 32'(q), 32'h81);
      en = 1'b0; mode = 3'd2; step(); chk("en0_hold", 32'(q), 32'h81);

      // burst of 3 to the left, en/mode toggled while busy
      en = 1'b1; mode = 3'd1; d = 8'h01; step();
      idle_inputs();
      busy_cnt = 0; done_cnt = 0;
      start = 1'b1; amt = AW'(3); dir = 1'b0; step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         en = (i < 2); mode = (i == 0) ? 3'd1 : 3'd3; d = 8'hFF;
         step();
         if (i >= 2) en = 1'b0;
      end
      en = 1'b0;
      chk("burst3_q", 32'(q), 32'h08);
      chk("burst3_busy_cycles", 32'(busy_cnt), 32'd3);
      chk("burst3_done_pulses", 32'(done_cnt), 32'd1);

      // zero amount: immediate done, no busy
      start = 1'b1; amt = '0; step();
      chk("amt0_done", 32'(done), 32'd1);
      chk("amt0_busy", 32'(busy), 32'd0);
      chk("amt0_q", 32'(q), 32'h08);
      start = 1'b0; step();
      chk("amt0_done_clear", 32'(done), 32'd0);

      // over-range amount clamps to W, filling with sin
      busy_cnt = 0; done_cnt = 0;
      start = 1'b1; amt = AW'(15); dir = 1'b1; sin = 1'b1; step();
      start = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("amt15_q", 32'(q), 32'hFF);
      chk("amt15_busy_cycles", 32'(busy_cnt), 32'd8);
      chk("amt15_done_pulses", 32'(done_cnt), 32'd1);

      // reset on the third busy cycle aborts the burst silently
      sin = 1'b0;
      start = 1'b1; amt = AW'(6); dir = 1'b0; step();
      start = 1'b0; step(); step();
      reset = 1'b1; step();
      chk("abort_q", 32'(q), 32'(RV));
      chk("abort_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 8; i++) step();
      chk("abort_no_done", 32'(done_cnt), 32'd0);

      // start held high: retriggers in the done cycle
      start = 1'b1; amt = AW'(2); sin = 1'b1;
      for (int i = 0; i < 8; i++) step();
      idle_inputs(); step();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         en    = 1'($urandom);
         mode  = 3'($urandom);
         d     = W'($urandom);
         sin   = 1'($urandom);
         start = ($urandom_range(0, 7) == 0);
         amt   = AW'($urandom_range(0, 15));
         dir   = 1'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
